countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counter with terminal-count pulse: the decrementing counterpart to the free-running up `counter` in the 8-bit computer. It accepts a start value over a valid/ready load port, counts down once per enabled cycle, and signals completion with a one-cycle `tc` pulse. It is used for delay loops, bus wait-states and step sequencing alongside the control unit.

## Interface
- `WIDTH`, 8: counter and load-value width in bits.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; the block is in reset while `reset`=0.
- `load_valid`  in  1  load request qualifier.
- `load_value`  in  WIDTH  start value.
- `load_ready`  out  1  high while the block can accept a load (IDLE only).
- `start`  in  1  begin counting from the current `value`.
- `pause`  in  1  hold count in RUN.
- `stop`  in  1  abort to IDLE, keeping the current `value`.
- `value`  out  WIDTH  current count, registered.
- `busy`  out  1  high in RUN or DONE.
- `tc`  out  1  terminal-count pulse, high exactly while in DONE.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, `value`=0, reload register=0, `tc`=0, `busy`=0, `load_ready`=1.
- IDLE:
  - A load handshake (`load_valid` & `load_ready`) writes `value` and the reload register with `load_value`.
  - `start` leaves IDLE. If the effective value is 0, the next state is DONE; otherwise it is RUN.
  - The effective value is `load_value` when a load happens in the same cycle; load applies before start.
  - `pause` and `stop` are ignored.
- RUN:
  - Priority is `stop` > `pause` > decrement.
  - `stop`: go to IDLE with `value` unchanged.
  - `pause`: hold.
  - Otherwise: if `value`==1, set `value` to 0 and go to DONE; else decrement `value`.
  - `load_valid` is ignored and `load_ready`=0.
- DONE lasts one cycle with `value`=0 and `tc`=1. The next cycle depends on the build (see Configuration). `stop` in DONE forces IDLE.
- Arithmetic:
  - Unsigned WIDTH-bit count, no wrap-around. The count never decrements past 0.
  - `value`=0 is never present in RUN.
- `start` while busy is ignored (no restart).

## Timing
- All outputs are registered. `load_ready`, `busy` and `tc` are decoded from registered state only, so there is no combinational input-to-output path.
- Load of N≥1 with `start` at edge 0:
  - RUN from cycle 1 with `value`=N.
  - `value`=1 at cycle N.
  - DONE and `tc`=1 at cycle N+1.
  - Total is N+1 cycles plus one extra cycle per paused cycle.
- Load of 0 with `start` at edge 0: DONE and `tc`=1 at cycle 1.
- `stop` takes effect at the next edge, and `tc` is not produced.
- Async reset mid-count: all outputs return to their reset values immediately. The count restarts only via a new load and `start`.

## Configuration
- `COUNTDOWN_AUTORELOAD_EN` defined: DONE reloads `value` from the reload register.
  - If the reload register is nonzero, the next state is RUN, giving a periodic `tc` every N+1 cycles.
  - If the reload register is 0, the block stays in DONE and `tc` stays high every cycle until `stop`.
- `COUNTDOWN_AUTORELOAD_EN` undefined: DONE always goes to IDLE with `value`=0. Counting is one-shot.

## Structure
- Shared package `countdown_pkg` holds:
  - the state enum typedef (IDLE/RUN/DONE);
  - the default width constant, used for `WIDTH`.
- Single module with no sub-module. The state register, count register and reload register are one clocked process; the next-state logic and output decode are combinational.

## Test plan
- Reset, then load 5 with `start` in the same cycle -> `value` sequence 5,4,3,2,1,0; `tc`=1 only at cycle 6; IDLE at cycle 7 with `load_ready`=1.
- Load 3, `start`, `pause` high for 2 cycles while `value`=2 -> `tc` at cycle 6; `value` held at 2 during the pause.
- Load 0, `start` -> `tc` at cycle 1, then IDLE.
- Load 10, `start`, `stop` at `value`=6 -> IDLE with `value`=6 and no `tc`; a later `start` -> `tc` 7 cycles later.
- `load_valid` with 9 during RUN, and `reset` low at `value`=4 -> the load is ignored; async clear to `value`=0 with `busy`=0 before the next edge.
- With `COUNTDOWN_AUTORELOAD_EN`, load 2 and `start` -> `tc` at cycles 3, 6 and 9; `stop` ends the sequence.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and defaults for the loadable countdown timer.
// Holds the FSM state encoding and the default count width.
package countdown_pkg;

    localparam int CD_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        CD_IDLE = 2'd0,
        CD_RUN  = 2'd1,
        CD_DONE = 2'd2
    } cd_state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter; value/reload load over a valid/ready port, one-cycle tc on reaching zero.
// Latency: load N + start -> tc N+1 cycles later, plus one cycle per paused cycle; outputs registered.
// Backpressure: load_ready is high only in IDLE, loads offered while busy are dropped.
// Build option COUNTDOWN_AUTORELOAD_EN: DONE reloads from the reload register for a periodic tc.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = CD_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             tc
);

    cd_state_e        state_q, state_nxt;
    logic [WIDTH-1:0] value_q, value_nxt;
    logic [WIDTH-1:0] reload_q, reload_nxt;

    always_comb begin
        state_nxt  = state_q;
        value_nxt  = value_q;
        reload_nxt = reload_q;
        case (state_q)
            CD_IDLE: begin
                if (load_valid && load_ready) begin
                    value_nxt  = load_value;
                    reload_nxt = load_value;
                end
                // start sees the freshly loaded value when both arrive together
                if (start) begin
                    state_nxt = (value_nxt == '0) ? CD_DONE : CD_RUN;
                end
            end
            CD_RUN: begin
                if (stop) begin
                    state_nxt = CD_IDLE;
                end else if (!pause) begin
                    if (value_q <= WIDTH'(1)) begin
                        value_nxt = '0;
                        state_nxt = CD_DONE;
                    end else begin
                        value_nxt = value_q - WIDTH'(1);
                    end
                end
            end
            CD_DONE: begin
                if (stop) begin
                    state_nxt = CD_IDLE;
                end else begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                    // a zero reload parks in DONE so tc stays asserted until stop
                    value_nxt = reload_q;
                    state_nxt = (reload_q == '0) ? CD_DONE : CD_RUN;
`else
                    value_nxt = '0;
                    state_nxt = CD_IDLE;
`endif
                end
            end
            default: begin
                value_nxt = '0;
                state_nxt = CD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= CD_IDLE;
            value_q  <= '0;
            reload_q <= '0;
        end else begin
            state_q  <= state_nxt;
            value_q  <= value_nxt;
            reload_q <= reload_nxt;
        end
    end

    assign value      = value_q;
    assign load_ready = (state_q == CD_IDLE);
    assign busy       = (state_q != CD_IDLE);
    assign tc         = (state_q == CD_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus randomized load/pause/stop runs,
// expected values derived from load value, decrements taken and cycle counts.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_value = 8'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] value;
    logic       load_ready;
    logic       busy;
    logic       tc;

    int n_checks = 0;
    int n_errors = 0;
    int cur = 0;

    countdown_timer #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .value      (value),
        .busy       (busy),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        load_valid = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        stop       = 1'b0;
    endtask

    task automatic check_idle(input string tag, input int exp_val);
        check({tag, "_rdy"},  int'(load_ready), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_tc"},   int'(tc), 0);
        check({tag, "_val"},  int'(value), exp_val);
    endtask

    // Start a count from n (loading n in the same cycle if use_load). Expected value
    // at each cycle is n minus the decrements taken so far; stop is raised in cycle stop_k.
    task automatic run_count(input int n, input bit use_load, input int stop_k,
                             input int pause_pct, input int pause_val, input int pause_len,
                             output int left);
        int d = 0;
        int k = 1;
        int plen = pause_len;
        bit p;
        if (use_load) begin
            load_valid = 1'b1;
            load_value = 8'(n);
        end
        start = 1'b1;
        tick();
        quiet();
        while (d < n) begin
            if (k > 1000) begin
                check("run_timeout", k, 0);
                left = n - d;
                return;
            end
            check("run_busy", int'(busy), 1);
            check("run_tc",   int'(tc), 0);
            check("run_rdy",  int'(load_ready), 0);
            check("run_val",  int'(value), n - d);
            load_valid = 1'($urandom);
            load_value = 8'($urandom);
            start      = 1'($urandom);
            p = ($urandom_range(0, 99) < pause_pct);
            if (plen > 0 && (n - d) == pause_val) begin
                p = 1'b1;
                plen--;
            end
            pause = p;
            stop  = (k == stop_k);
            tick();
            k++;
            if (stop) begin
                quiet();
                check_idle("stop", n - d);
                left = n - d;
                return;
            end
            if (!p) d++;
        end
        quiet();
        check("done_tc",   int'(tc), 1);
        check("done_val",  int'(value), 0);
        check("done_busy", int'(busy), 1);
        check("done_rdy",  int'(load_ready), 0);
`ifdef COUNTDOWN_AUTORELOAD_EN
        stop = 1'b1;
`else
        stop  = 1'($urandom);
        pause = 1'($urandom);
`endif
        tick();
        quiet();
        check_idle("after_done", 0);
        left = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #12;
        check_idle("reset", 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_idle("post_reset", 0);

        // load 5 with start: 5,4,3,2,1 then tc at cycle 6, idle at 7
        run_count(5, 1'b1, -1, 0, 0, 0, cur);
        // load 3, pause two cycles while value is 2: tc at cycle 6
        run_count(3, 1'b1, -1, 0, 2, 2, cur);
        // load 0: tc at cycle 1
        run_count(0, 1'b1, -1, 0, 0, 0, cur);
        // load 10, stop at value 6, then resume from 6: tc 7 cycles later
        run_count(10, 1'b1, 5, 0, 0, 0, cur);
        check("stop_held", int'(value), 6);
        run_count(6, 1'b0, -1, 0, 0, 0, cur);

        // load ignored while running, then async reset at value 4
        load_valid = 1'b1;
        load_value = 8'd6;
        start      = 1'b1;
        tick();
        quiet();
        for (int c = 0; c < 2; c++) begin
            check("rst_run_val", int'(value), 6 - c);
            load_valid = 1'b1;
            load_value = 8'd9;
            tick();
        end
        quiet();
        check("rst_val4", int'(value), 4);
        #2 reset = 1'b0;
        #1 check_idle("async_rst", 0);
        #2 reset = 1'b1;
        tick();
        check_idle("post_async", 0);

        // idle: load without start, pause/stop ignored
        load_valid = 1'b1;
        load_value = 8'd7;
        tick();
        quiet();
        check_idle("preload", 7);
        pause = 1'b1;
        stop  = 1'b1;
        tick();
        quiet();
        check_idle("idle_hold", 7);
        run_count(7, 1'b0, -1, 0, 0, 0, cur);

`ifdef COUNTDOWN_AUTORELOAD_EN
        load_valid = 1'b1;
        load_value = 8'd2;
        start      = 1'b1;
        tick();
        quiet();
        for (int c = 1; c <= 9; c++) begin
            check("ar_tc",  int'(tc), (c % 3 == 0) ? 1 : 0);
            check("ar_val", int'(value), 2 - ((c - 1) % 3));
            if (c == 9) stop = 1'b1;
            tick();
        end
        quiet();
        check_idle("ar_stop", 0);
        load_valid = 1'b1;
        load_value = 8'd0;
        start      = 1'b1;
        tick();
        quiet();
        for (int c = 1; c <= 4; c++) begin
            check("ar0_tc",   int'(tc), 1);
            check("ar0_busy", int'(busy), 1);
            if (c == 4) stop = 1'b1;
            tick();
        end
        quiet();
        check_idle("ar0_stop", 0);
`endif

        for (int it = 0; it < 40; it++) begin
            int n;
            int sk;
            bit pre;
            pre = ($urandom_range(0, 3) == 0);
            n   = int'($urandom_range(0, 20));
            if (pre) begin
                load_valid = 1'b1;
                load_value = 8'(n);
                tick();
                quiet();
                check_idle("rnd_preload", n);
                pause = 1'($urandom);
                stop  = 1'($urandom);
                tick();
                quiet();
                check_idle("rnd_idle_hold", n);
            end
            sk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n + 3)) : -1;
            run_count(n, !pre, sk, 25, 0, 0, cur);
            if (cur != 0 && $urandom_range(0, 1) == 1) begin
                run_count(cur, 1'b0, -1, 25, 0, 0, cur);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
